// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

   // Frame deserialiser states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
   // Bits captured after the start bit: 8 data, parity, stop.
   localparam int         PS2_FRAME_BITS = 10;

   // One decoded key event as stored in the FIFO.
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } ps2_event_t;

endpackage

// File: rtl/ps2_clk_filter.sv
// Pin synchronisers plus a FILTER_LEN-deep glitch filter on ps2c.
// Emits a one-cycle strobe on each filtered falling edge of ps2c.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2c,
   input  logic ps2d,
   output logic strobe,
   output logic ps2d_sync
);

   logic [1:0]            c_sync;
   logic [1:0]            d_sync;
   logic [FILTER_LEN-1:0] c_hist;
   logic                  c_filt;

   // Two-flop synchronisers; reset to the idle-high bus level.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         c_sync <= 2'b11;
         d_sync <= 2'b11;
      end else begin
         c_sync <= {c_sync[0], ps2c};
         d_sync <= {d_sync[0], ps2d};
      end
   end

   assign ps2d_sync = d_sync[1];

   // Filtered clock flips only on a full run of equal samples; strobe marks 1->0.
   always_ff @(posedge clk) begin
      if (reset) begin
         c_hist <= '1;
         c_filt <= 1'b1;
         strobe <= 1'b0;
      end else begin
         c_hist <= {c_hist[FILTER_LEN-2:0], c_sync[1]};
         strobe <= 1'b0;
         if (&c_hist) begin
            c_filt <= 1'b1;
         end else if (c_hist == '0) begin
            c_filt <= 1'b0;
            strobe <= c_filt;
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix folding and a
// first-word-fall-through event FIFO behind a valid/ready port.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ps2c,
   input  logic                          ps2d,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [7:0]                    ev_code,
   output logic                          ev_ext,
   output logic                          ev_release,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic                      strobe;
   logic                      ps2d_s;
   state_t                    state, state_next;
   logic [3:0]                bit_cnt;
   logic [PS2_FRAME_BITS-1:0] shift_reg;
   logic                      frame_good, frame_bad, timeout;
   logic                      ext_pend, rel_pend;
   logic                      ev_push;
   ps2_event_t                push_ev;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk       (clk),
      .reset     (reset),
      .ps2c      (ps2c),
      .ps2d      (ps2d),
      .strobe    (strobe),
      .ps2d_sync (ps2d_s)
   );

`ifdef PS2_RX_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WDW-1:0] wd_cnt;

   // Watchdog: counts cycles between strobes while a frame is in progress.
   always_ff @(posedge clk) begin
      if (reset || state != SHIFT || strobe) wd_cnt <= '0;
      else                                   wd_cnt <= wd_cnt + 1'b1;
   end

   assign timeout = (state == SHIFT) && !strobe && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // Frame FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Frame FSM next state and frame verdict.
   // NOTE: every output of this block is defaulted first so no latch is inferred.
   always_comb begin
      state_next = state;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         IDLE:    if (strobe && !ps2d_s) state_next = SHIFT;
         SHIFT: begin
            if (timeout)                        state_next = IDLE;
            else if (strobe && bit_cnt == 4'd1) state_next = CHECK;
         end
         CHECK: begin
            state_next = IDLE;
            if ((^shift_reg[8:0]) && shift_reg[9]) frame_good = 1'b1;
            else                                   frame_bad  = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bit counter and LSB-first shift register.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (state == IDLE && strobe) begin
         bit_cnt <= 4'(PS2_FRAME_BITS);
      end else if (state == SHIFT && strobe) begin
         shift_reg <= {ps2d_s, shift_reg[PS2_FRAME_BITS-1:1]};
         bit_cnt   <= bit_cnt - 4'd1;
      end
   end

   // Prefix decoder: non-prefix good bytes become events.
   always_comb begin
      push_ev = '{code: shift_reg[7:0], ext: ext_pend, rel: rel_pend};
      ev_push = frame_good && (shift_reg[7:0] != PS2_EXT_PREFIX) &&
                (shift_reg[7:0] != PS2_BRK_PREFIX);
   end

   // Pending prefix flags; cleared by any event, bad frame or watchdog expiry.
   always_ff @(posedge clk) begin
      if (reset || frame_bad || timeout || ev_push) begin
         ext_pend <= 1'b0;
         rel_pend <= 1'b0;
      end else if (frame_good) begin
         if (shift_reg[7:0] == PS2_EXT_PREFIX) ext_pend <= 1'b1;
         if (shift_reg[7:0] == PS2_BRK_PREFIX) rel_pend <= 1'b1;
      end
   end

   // ---------------- Event FIFO ----------------
   ps2_event_t    mem [FIFO_DEPTH];
   ps2_event_t    head;
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [AW:0]   level, level_next;
   logic          pop, full, accept;

   assign ev_valid = (level != '0);
   assign pop      = ev_valid && ev_ready;
   assign full     = (level == (AW+1)'(FIFO_DEPTH));
   assign accept   = ev_push && (!full || pop);

   // FIFO pointer/level look-ahead used to preload the head register.
   always_comb begin
      rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
      level_next = level + (AW+1)'(accept) - (AW+1)'(pop);
   end

   // Storage array write port.
   // NOTE: the array is not reset; nothing reads an entry before it is written.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= push_ev;
   end

   // Pointers, level, head register and status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         head      <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr    <= rd_next;
         level     <= level_next;
         frame_err <= frame_bad || timeout;
         overflow  <= ev_push && !accept;
         // Head holds its last value once the FIFO runs empty.
         if (level_next != '0)
            head <= (accept && rd_next == wr_ptr) ? push_ev : mem[rd_next];
      end
   end

   assign ev_code    = head.code;
   assign ev_ext     = head.ext;
   assign ev_release = head.rel;
   assign fifo_level = level;

endmodule
